// File: rtl/flfx_if.sv
// Handshake bundle for the float-to-fixed converter: float input side and fixed output side.
interface flfx_if;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] m;
   logic [3:0] e;
   logic       out_valid;
   logic       out_ready;
   logic [6:0] fx;
   logic       ovf;

   modport master (
      output in_valid, m, e, out_ready,
      input  in_ready, out_valid, fx, ovf
   );

   modport slave (
      input  in_valid, m, e, out_ready,
      output in_ready, out_valid, fx, ovf
   );
endinterface

// File: rtl/flfx.sv
// Sequential float-to-fixed converter: fx = m * 2^e (Q0.3 mantissa to saturated Q0.6),
// one bit of shift per cycle.
module flfx (
   input logic   clk,
   input logic   rst,
   flfx_if.slave bus
);
   localparam int unsigned ACC_W = 7;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t             state, state_n;
   logic [ACC_W-1:0]   acc, acc_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic               dir, dir_n;
   logic               sat, sat_n;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         acc   <= '0;
         cnt   <= '0;
         dir   <= 1'b0;
         sat   <= 1'b0;
      end else begin
         state <= state_n;
         acc   <= acc_n;
         cnt   <= cnt_n;
         dir   <= dir_n;
         sat   <= sat_n;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_n = state;
      acc_n   = acc;
      cnt_n   = cnt;
      dir_n   = dir;
      sat_n   = sat;
      case (state)
         IDLE: begin
            if (bus.in_valid) begin
               acc_n   = {bus.m, 3'b000};
               cnt_n   = bus.e[3] ? CNT_W'(~bus.e + 4'd1) : bus.e;
               dir_n   = bus.e[3];
               sat_n   = 1'b0;
               state_n = (bus.e == 4'd0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            cnt_n = cnt - CNT_W'(1);
            if (dir) begin
               acc_n = {acc[6], acc[6:1]};
            end else if ((acc[6] != acc[5]) || sat) begin
               // Sign bit still holds the mantissa sign, so it selects the rail
               acc_n = acc[6] ? 7'b1000000 : 7'b0111111;
               sat_n = 1'b1;
            end else begin
               acc_n = {acc[5:0], 1'b0};
            end
            if (cnt == CNT_W'(1)) state_n = DONE;
         end
         DONE: begin
            if (bus.out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.in_ready  = (state == IDLE) && !rst;
   assign bus.out_valid = (state == DONE);
   assign bus.fx        = acc;
   assign bus.ovf       = sat;
endmodule

// File: tb/tb_flfx.sv
// Directed and exhaustive checks for flfx: table vectors, backpressure, mid-flight reset.
module tb_flfx;
   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   flfx_if bif ();

   flfx dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] m;
      logic [3:0] e;
      logic [6:0] fx;
      logic       ovf;
      int         lat;
   } vec_t;

   vec_t tbl [11];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // sat7(floor(m * 2^(e+3))) on the raw integer encodings
   task automatic model(input logic [3:0] mi, input logic [3:0] ei,
                        output logic [6:0] f, output logic o);
      int mv, ev, sh, v;
      mv = int'($signed(mi));
      ev = int'($signed(ei));
      sh = ev + 3;
      if (sh >= 0) v = mv * (1 << sh);
      else         v = mv >>> (-sh);
      if (v > 63) begin
         f = 7'b0111111; o = 1'b1;
      end else if (v < -64) begin
         f = 7'b1000000; o = 1'b1;
      end else begin
         f = 7'(v); o = 1'b0;
      end
   endtask

   // One conversion; called at posedge+1 of an idle cycle
   task automatic run(input logic [3:0] mi, input logic [3:0] ei, input int stall,
                      output logic [6:0] fo, output logic oo, output int lat);
      int w;
      bif.m        = mi;
      bif.e        = ei;
      bif.in_valid = 1'b1;
      bif.out_ready = 1'b0;
      w = 0;
      while (!bif.in_ready && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      if (!bif.in_ready) chk("accept_timeout", 0, 1);
      @(posedge clk); #1;
      bif.in_valid = 1'b0;
      bif.m        = ~mi;
      bif.e        = ~ei;
      lat = 1;
      while (!bif.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!bif.out_valid) chk("valid_timeout", 0, 1);
      fo = bif.fx;
      oo = bif.ovf;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         chk("stall_hold", int'({bif.out_valid, bif.ovf, bif.fx}), int'({1'b1, oo, fo}));
      end
      bif.out_ready = 1'b1;
      @(posedge clk); #1;
      bif.out_ready = 1'b0;
   endtask

   initial begin
      logic [6:0] fo, fe;
      logic       oo, oe;
      int         lat;
      int         ae;
      bit         seen;

      n_cmp = 0;
      n_bad = 0;
      tbl[0]  = '{4'b0100, 4'b1011, 7'b0000001, 1'b0, 6};
      tbl[1]  = '{4'b1000, 4'b1010, 7'b1111111, 1'b0, 7};
      tbl[2]  = '{4'b0101, 4'b0000, 7'b0101000, 1'b0, 1};
      tbl[3]  = '{4'b0111, 4'b1000, 7'b0000000, 1'b0, 9};
      tbl[4]  = '{4'b0100, 4'b0001, 7'b0111111, 1'b1, 2};
      tbl[5]  = '{4'b1100, 4'b0001, 7'b1000000, 1'b0, 2};
      tbl[6]  = '{4'b1000, 4'b0111, 7'b1000000, 1'b1, 8};
      tbl[7]  = '{4'b1000, 4'b0000, 7'b1000000, 1'b0, 1};
      tbl[8]  = '{4'b0000, 4'b0111, 7'b0000000, 1'b0, 8};
      tbl[9]  = '{4'b1111, 4'b1000, 7'b1111111, 1'b0, 9};
      tbl[10] = '{4'b0111, 4'b0011, 7'b0111111, 1'b1, 4};

      bif.in_valid  = 1'b0;
      bif.out_ready = 1'b0;
      bif.m         = 4'd0;
      bif.e         = 4'd0;
      rst           = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", int'(bif.in_ready), 0);
      chk("rst_out_valid", int'(bif.out_valid), 0);
      chk("rst_fx", int'(bif.fx), 0);
      chk("rst_ovf", int'(bif.ovf), 0);
      rst = 1'b0;
      #1;
      chk("rel_in_ready", int'(bif.in_ready), 1);

      // Table vectors with out_ready effectively held high
      for (int i = 0; i < 11; i++) begin
         run(tbl[i].m, tbl[i].e, 0, fo, oo, lat);
         chk($sformatf("vec%0d_fx", i), int'(fo), int'(tbl[i].fx));
         chk($sformatf("vec%0d_ovf", i), int'(oo), int'(tbl[i].ovf));
         chk($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
         chk($sformatf("vec%0d_in_ready", i), int'(bif.in_ready), 1);
      end

      // Backpressure: 6*2^2 = 24, hold 5 cycles while a new input waits
      bif.m = 4'b0110; bif.e = 4'b1111; bif.in_valid = 1'b1; bif.out_ready = 1'b0;
      @(posedge clk); #1;
      bif.m = 4'b0001; bif.e = 4'b0000;
      @(posedge clk); #1;
      chk("bp_valid", int'(bif.out_valid), 1);
      chk("bp_fx", int'(bif.fx), int'(7'b0011000));
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_hold_fx", int'(bif.fx), int'(7'b0011000));
         chk("bp_hold_ovf", int'(bif.ovf), 0);
         chk("bp_hold_in_ready", int'(bif.in_ready), 0);
         chk("bp_hold_valid", int'(bif.out_valid), 1);
      end
      bif.out_ready = 1'b1;
      @(posedge clk); #1;
      bif.out_ready = 1'b0;
      chk("bp_xfer_valid", int'(bif.out_valid), 0);
      chk("bp_xfer_in_ready", int'(bif.in_ready), 1);
      @(posedge clk); #1;
      bif.in_valid = 1'b0;
      chk("bp_next_valid", int'(bif.out_valid), 1);
      chk("bp_next_fx", int'(bif.fx), int'(7'b0001000));
      bif.out_ready = 1'b1;
      @(posedge clk); #1;
      bif.out_ready = 1'b0;

      // Reset during a long right shift
      bif.m = 4'b0100; bif.e = 4'b1000; bif.in_valid = 1'b1;
      chk("mr_in_ready", int'(bif.in_ready), 1);
      @(posedge clk); #1;
      bif.in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("mr_rst_in_ready", int'(bif.in_ready), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("mr_in_ready_after", int'(bif.in_ready), 1);
      chk("mr_fx", int'(bif.fx), 0);
      chk("mr_ovf", int'(bif.ovf), 0);
      bif.out_ready = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (bif.out_valid) seen = 1'b1;
         @(posedge clk); #1;
      end
      bif.out_ready = 1'b0;
      chk("mr_no_valid", int'(seen), 0);

      // Exhaustive with random stalls
      for (int mi = 0; mi < 16; mi++) begin
         for (int ei = 0; ei < 16; ei++) begin
            run(4'(mi), 4'(ei), int'($urandom_range(0, 2)), fo, oo, lat);
            model(4'(mi), 4'(ei), fe, oe);
            ae = (ei >= 8) ? 16 - ei : ei;
            chk($sformatf("ex_m%0d_e%0d_fx", mi, ei), int'(fo), int'(fe));
            chk($sformatf("ex_m%0d_e%0d_ovf", mi, ei), int'(oo), int'(oe));
            chk($sformatf("ex_m%0d_e%0d_lat", mi, ei), lat, 1 + ae);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
